// File: rtl/spi_flash_xip_pkg.sv
// Shared constants for the SPI NOR execute-in-place read window.
package spi_flash_xip_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_DESEL  = 4'd1;
  localparam logic [3:0] ST_CMD    = 4'd2;
  localparam logic [3:0] ST_CMD_RX = 4'd3;
  localparam logic [3:0] ST_DAT    = 4'd4;
  localparam logic [3:0] ST_DAT_RX = 4'd5;
  localparam logic [3:0] ST_ACK    = 4'd6;
  localparam logic [3:0] ST_HOLD   = 4'd7;
  localparam logic [3:0] ST_WACK   = 4'd8;

  localparam logic [7:0]  RD_CMD_DEF = 8'h03;
  localparam logic [31:0] DUMMY_WORD = 32'hFFFF_FFFF;

  // One counter serves both the hold timeout and the deselect gap.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/spi_flash_xip.sv
// Wishbone read-only window onto SPI NOR flash (cmd 0x03); keeps ss low between
// sequential reads so a next-word access only shifts one dummy word.
module spi_flash_xip
  import spi_flash_xip_pkg::*;
#(
  parameter int         AW        = 22,
  parameter int         HOLD_CYC  = 64,
  parameter int         DESEL_CYC = 4,
  parameter logic [7:0] RD_CMD    = RD_CMD_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic [AW-1:0] adr_i,
  input  logic          we_i,
  input  logic [3:0]    sel_i,
  output logic          ack_o,
  output logic [31:0]   dat_o,
  output logic          spi_quad,
  output logic [31:0]   spi_din,
  output logic          spi_din_valid,
  input  logic          spi_din_ready,
  input  logic [31:0]   spi_dout,
  input  logic          spi_dout_valid,
  output logic          spi_dout_ready,
  output logic          ss
);

  localparam int            CW         = cnt_width(HOLD_CYC, DESEL_CYC);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] DESEL_LAST = CW'(DESEL_CYC - 1);

  logic [3:0]    state, state_n;
  logic [21:0]   adr_q, next_adr;
  logic [CW-1:0] cnt;
  logic          wack_hold;
  logic          req, rd_req, wr_req;
  logic          ss_n;
  logic          unused_in;

  assign unused_in = ^{sel_i, adr_i};

  assign req    = cyc_i & stb_i & ~ack_o;
  assign rd_req = req & ~we_i;
  assign wr_req = req & we_i;

  assign spi_quad       = 1'b1;
  assign spi_din_valid  = (state == ST_CMD) || (state == ST_DAT);
  assign spi_din        = (state == ST_CMD) ? {RD_CMD, adr_q, 2'b00} : DUMMY_WORD;
  assign spi_dout_ready = (state == ST_CMD_RX) || (state == ST_DAT_RX);
  // A master that abandoned the cycle during the shift gets no ack.
  assign ack_o          = ((state == ST_ACK) && cyc_i) || (state == ST_WACK);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (rd_req) state_n = ST_CMD;
                 else if (wr_req) state_n = ST_WACK;
      ST_DESEL:  if (cnt == DESEL_LAST) state_n = ST_CMD;
      ST_CMD:    if (spi_din_ready) state_n = ST_CMD_RX;
      ST_CMD_RX: if (spi_dout_valid) state_n = ST_DAT;
      ST_DAT:    if (spi_din_ready) state_n = ST_DAT_RX;
      ST_DAT_RX: if (spi_dout_valid) state_n = ST_ACK;
      ST_ACK:    state_n = ST_HOLD;
      ST_HOLD:   if (rd_req) state_n = (adr_i[21:0] == next_adr) ? ST_DAT : ST_DESEL;
                 else if (wr_req) state_n = ST_WACK;
                 else if (cnt == HOLD_LAST) state_n = ST_IDLE;
      ST_WACK:   state_n = wack_hold ? ST_HOLD : ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_n)
      ST_IDLE, ST_DESEL: ss_n = 1'b1;
      ST_WACK:           ss_n = ss;
      default:           ss_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      ss        <= 1'b1;
      dat_o     <= '0;
      adr_q     <= '0;
      next_adr  <= '0;
      cnt       <= '0;
      wack_hold <= 1'b0;
    end else begin
      state <= state_n;
      ss    <= ss_n;
      if (((state == ST_IDLE) || (state == ST_HOLD)) && rd_req)
        adr_q <= adr_i[21:0];
      if (state_n == ST_WACK)
        wack_hold <= (state == ST_HOLD);
      if ((state == ST_DAT_RX) && spi_dout_valid) begin
        dat_o    <= spi_dout;
        next_adr <= adr_q + 22'd1;
      end
      if ((state_n == ST_DESEL) && (state != ST_DESEL))
        cnt <= '0;
      else if (state == ST_DESEL)
        cnt <= cnt + 1'b1;
      else if ((state == ST_ACK) || (state == ST_IDLE))
        cnt <= '0;
      else if ((state == ST_HOLD) && !req)
        cnt <= cnt + 1'b1;
    end
  end

endmodule
